// File: rtl/hist_mem_arbiter.sv
// hist_mem_arbiter: round-robin sequencer of the histogram data memory between core single-word accesses and host read bursts
//   core_*  : single-word read/write requester (req held until gnt, rvalid/rdata one cycle after issue)
//   host_*  : burst read requester (len 0 = BURST_MAX, gnt on first issue, busy..done framing)
//   mem_*   : single-port synchronous memory, 1-cycle read latency
module hist_mem_arbiter #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 8,
  parameter int BURST_MAX = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_req,
  input  logic                         core_we,
  input  logic [ADDR_W-1:0]            core_addr,
  input  logic [DATA_W-1:0]            core_wdata,
  output logic                         core_gnt,
  output logic                         core_rvalid,
  output logic [DATA_W-1:0]            core_rdata,
  input  logic                         host_req,
  input  logic [ADDR_W-1:0]            host_addr,
  input  logic [$clog2(BURST_MAX)-1:0] host_len,
  output logic                         host_gnt,
  output logic                         host_busy,
  output logic                         host_rvalid,
  output logic [DATA_W-1:0]            host_rdata,
  output logic                         host_done,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);
  localparam int CW = $clog2(BURST_MAX);
  typedef enum logic [1:0] {IDLE, CORE, HOST, DRAIN} state_t;
  state_t state, state_nx;
  logic lat_we, last_host, core_rv, host_rv, pick_core, pick_host, burst_end;
  logic [CW-1:0] cnt, len;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign pick_core = core_req & (~host_req | last_host);
  assign pick_host = host_req & ~pick_core;
  // len-1 wraps to all ones for len=0, which is exactly BURST_MAX-1
  assign burst_end = cnt == len - CW'(1);
  always_comb begin
    state_nx    = (state == IDLE) ? (pick_core ? CORE : pick_host ? HOST : IDLE) :
                  (state == HOST) ? (burst_end ? DRAIN : HOST) : IDLE;
    core_gnt    = state == CORE;
    core_rvalid = core_rv;
    core_rdata  = mem_rdata;
    host_gnt    = (state == HOST) && (cnt == '0);
    host_busy   = (state == HOST) || (state == DRAIN);
    host_rvalid = host_rv;
    host_rdata  = mem_rdata;
    host_done   = state == DRAIN;
    mem_en      = (state == CORE) || (state == HOST);
    mem_we      = (state == CORE) && lat_we;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
  end
  // the address register is loaded with the base and stepped during the burst,
  // so mem_addr naturally holds its last value when the memory is idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      last_host <= 1'b1;
      cnt       <= '0;
      len       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      core_rv   <= 1'b0;
      host_rv   <= 1'b0;
    end else begin
      state   <= state_nx;
      core_rv <= (state == CORE) && !lat_we;
      host_rv <= state == HOST;
      if (state == IDLE && pick_core) begin
        lat_we  <= core_we;
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
      end
      if (state == IDLE && pick_host) begin
        addr_q <= host_addr;
        len    <= host_len;
        cnt    <= '0;
      end
      if (state == HOST) begin
        cnt       <= cnt + CW'(1);
        addr_q    <= burst_end ? addr_q : addr_q + ADDR_W'(1);
        last_host <= 1'b1;
      end
      if (state == CORE) last_host <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hist_mem_arbiter.sv
// tb_hist_mem_arbiter: directed table-driven bench for hist_mem_arbiter with a behavioural memory
module tb_hist_mem_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic core_req = 1'b0, core_we = 1'b0;
  logic [7:0] core_addr = '0, host_addr = '0, mem_addr;
  logic [127:0] core_wdata = '0, core_rdata, host_rdata, mem_wdata, mem_rdata;
  logic host_req = 1'b0;
  logic [3:0] host_len = '0;
  logic core_gnt, core_rvalid, host_gnt, host_busy, host_rvalid, host_done, mem_en, mem_we;
  int errors = 0, checks = 0;
  typedef struct {
    logic         we;
    logic [7:0]   addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } cvec_t;
  cvec_t tbl [6];
  logic [127:0] mem [256];
  logic [255:0] wr_v = '0;
  hist_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_len(host_len),
    .host_gnt(host_gnt), .host_busy(host_busy), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_done(host_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] pat(logic [7:0] a);
    return {16{a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]  <= mem_wdata;
        wr_v[mem_addr] <= 1'b1;
      end
      mem_rdata <= wr_v[mem_addr] ? mem[mem_addr] : pat(mem_addr);
    end
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic core_acc(cvec_t v);
    core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata;
    chk("core_gnt_early", core_gnt, 0);
    @(negedge clk);
    chk("core_gnt", core_gnt, 1);
    chk("core_mem_en", mem_en, 1);
    chk("core_mem_we", mem_we, v.we);
    chk("core_mem_addr", mem_addr, v.addr);
    if (v.we) chk("core_mem_wdata", mem_wdata, v.wdata);
    core_req = 1'b0;
    @(negedge clk);
    chk("core_rvalid", core_rvalid, !v.we);
    if (!v.we) chk("core_rdata", core_rdata, v.exp);
  endtask
  task automatic host_burst(logic [7:0] a, logic [3:0] l);
    int n = (l == 0) ? 16 : int'(l);
    logic [7:0] ea;
    host_req = 1'b1; host_addr = a; host_len = l;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ea = a + 8'(i);
      chk("host_mem_en", mem_en, 1);
      chk("host_mem_we", mem_we, 0);
      chk("host_mem_addr", mem_addr, ea);
      chk("host_gnt", host_gnt, i == 0);
      chk("host_busy", host_busy, 1);
      chk("host_rvalid", host_rvalid, i > 0);
      chk("host_done_early", host_done, 0);
      if (i > 0) chk("host_rdata", host_rdata, pat(ea - 8'd1));
      host_req = 1'b0;
    end
    @(negedge clk);
    ea = a + 8'(n - 1);
    chk("drain_mem_en", mem_en, 0);
    chk("drain_rvalid", host_rvalid, 1);
    chk("drain_done", host_done, 1);
    chk("drain_busy", host_busy, 1);
    chk("drain_rdata", host_rdata, pat(ea));
    @(negedge clk);
    chk("post_busy", host_busy, 0);
    chk("post_rvalid", host_rvalid, 0);
    chk("post_done", host_done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int gcyc, dcyc, iss, rv, seen;
    tbl[0] = '{1'b1, 8'h10, 128'hA5, 128'h0};
    tbl[1] = '{1'b0, 8'h10, 128'h0, 128'hA5};
    tbl[2] = '{1'b1, 8'h7F, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h0};
    tbl[3] = '{1'b0, 8'h7F, 128'h0, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321};
    tbl[4] = '{1'b1, 8'hA0, {4{32'hDEAD_BEEF}}, 128'h0};
    tbl[5] = '{1'b0, 8'hA0, 128'h0, {4{32'hDEAD_BEEF}}};
    repeat (2) @(negedge clk);
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_host_busy", host_busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) core_acc(tbl[i]);
    host_burst(8'hFE, 4'd3);
    for (int k = 0; k < 4; k++) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h30; core_wdata = 128'hF00D;
      host_req = 1'b1; host_addr = 8'h40; host_len = 4'd1;
      @(negedge clk);
      chk("alt_core_gnt", core_gnt, (k % 2) == 0);
      chk("alt_host_gnt", host_gnt, (k % 2) == 1);
      core_req = 1'b0; host_req = 1'b0;
      repeat (3) @(negedge clk);
    end
    host_req = 1'b1; host_addr = 8'h80; host_len = 4'd0;
    gcyc = -1; dcyc = -1; iss = 0; rv = 0;
    @(negedge clk);
    host_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20; core_wdata = 128'hBEEF;
    for (int c = 0; c < 40 && gcyc < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_en && !mem_we && !core_gnt) iss++;
      if (host_rvalid) rv++;
      if (host_done) dcyc = c;
      if (core_gnt) begin
        gcyc = c;
        core_req = 1'b0;
      end
    end
    chk("len0_issues", iss, 16);
    chk("len0_rvalids", rv, 16);
    chk("len0_done_cycle", dcyc, 16);
    chk("len0_core_gnt_cycle", gcyc, 18);
    @(negedge clk);
    chk("len0_core_rvalid", core_rvalid, 1);
    chk("len0_core_rdata", core_rdata, pat(8'h20));
    host_req = 1'b1; host_addr = 8'h50; host_len = 4'd4;
    @(negedge clk);
    chk("rb_host_gnt", host_gnt, 1);
    host_req = 1'b0;
    @(negedge clk);
    chk("rb_second_addr", mem_addr, 8'h51);
    #1 reset = 1'b0;
    #1;
    chk("rb_core_gnt", core_gnt, 0);
    chk("rb_core_rvalid", core_rvalid, 0);
    chk("rb_host_gnt0", host_gnt, 0);
    chk("rb_host_busy", host_busy, 0);
    chk("rb_host_rvalid", host_rvalid, 0);
    chk("rb_host_done", host_done, 0);
    chk("rb_mem_en", mem_en, 0);
    chk("rb_mem_we", mem_we, 0);
    chk("rb_mem_addr", mem_addr, 0);
    chk("rb_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    chk("rb_hold_done", host_done, 0);
    chk("rb_hold_rvalid", host_rvalid, 0);
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (host_done || host_rvalid || host_busy || mem_en) seen++;
    end
    chk("rb_quiet_after", seen, 0);
    core_acc(tbl[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
